parity_frame_checker: RTL
=========================

Name: parity_frame_checker

Overview:
- Sequential, parametrised successor to the team's 4-bit combinational even-parity checker.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates parity across a frame of FRAME_LEN words.
- At frame end, checks the accumulated parity against a received parity bit in even or odd mode, presents the result on a held output handshake, and keeps a saturating error count.
- Sits between a serial/word receiver and the link-status logic.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- FRAME_LEN, 4, words per frame (>=1).
- CNT_W, 8, error counter width (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity; latched on first word of frame.
- frame_abort  input  1  synchronous discard of a partial frame.
- in_valid  input  1  in_data valid.
- in_ready  output  1  checker can accept a word.
- in_data  input  WIDTH  data word.
- in_parity  input  1  received frame parity bit; sampled only with the last word.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts result.
- out_err  output  1  1 = frame parity mismatch.
- out_parity  output  1  computed XOR of all frame data bits.
- err_count  output  CNT_W  saturating count of accepted error results.

Behaviour:
- Async reset (rst_n=0): state IDLE, acc=0, word count=0, out_valid=0, out_err=0, out_parity=0, err_count=0, in_ready=1. Reset mid-frame discards the frame.
- Transfer occurs when in_valid & in_ready; out transfer occurs when out_valid & out_ready.
- States:
  - IDLE: in_ready=1. Word accepted -> latch odd_mode into mode_q, acc = ^in_data, cnt=1, go to ACCUM. If FRAME_LEN=1, go directly to REPORT.
  - ACCUM: in_ready=1. Each accepted word does acc ^= ^in_data and cnt++.
  - REPORT: in_ready=0, out_valid=1.
- Last word = accept with cnt==FRAME_LEN-1 (or the first word when FRAME_LEN=1). On the last word:
  - p = acc ^ (^in_data).
  - out_parity <= p.
  - out_err <= p ^ in_parity ^ mode_q; for a FRAME_LEN=1 frame, use odd_mode from the same cycle.
  - Next state REPORT.
- Latency: out_valid asserts the cycle after the last word is accepted.
- REPORT holds out_valid, out_err and out_parity stable until out_ready=1. On that cycle:
  - err_count increments if out_err=1, saturating at all-ones.
  - Next state IDLE with acc=0, cnt=0, out_valid=0.
  - No new word is accepted on the same cycle; in_ready=1 again the following cycle.
- odd_mode changes mid-frame have no effect; mode_q is used.
- frame_abort=1 in IDLE/ACCUM: acc=0, cnt=0, state IDLE. A word presented the same cycle is dropped; abort wins, although in_ready stays 1.
- frame_abort in REPORT: ignored; the pending result is still delivered.
- in_parity is ignored on non-last words.
- Counter wrap: cnt never exceeds FRAME_LEN-1; err_count never wraps.

Optional Feature:
- Macro: PARITY_FRAME_WORD_CHECK_EN.
- Defined:
  - Extra input in_word_parity (1 bit), checked on every accepted word: word_bad = (^in_data) ^ in_word_parity ^ mode.
  - A sticky flag ORs word_bad across the frame.
  - Extra output out_word_err (1 bit) is presented with the result, held like out_err, and cleared on reset, abort or result acceptance.
  - err_count increments if out_err | out_word_err.
- Undefined: neither port exists; err_count depends on out_err only.

Test Plan:
- Assert rst_n=0 mid-frame (2 words in), then release -> out_valid=0, err_count=0, in_ready=1. Next full frame is judged from scratch.
- WIDTH=8, FRAME_LEN=4, odd_mode=0, words 0x01,0x03,0x00,0x00, in_parity=1, out_ready=1 -> out_valid=1 one cycle after the 4th word, out_parity=1, out_err=0, err_count stays 0.
- Same frame, in_parity=0 -> out_err=1, err_count=1 after acceptance. Repeat with odd_mode=1 and in_parity=0 -> out_err=0.
- Error frame with out_ready=0 for 3 cycles -> out_valid/out_err held, in_ready=0, err_count unchanged until the out_ready cycle, then +1.
- 2 words sent, then frame_abort=1 with in_valid=1 -> word dropped. Next 4-word frame of all 0xFF with in_parity=0 -> out_err=0.
- CNT_W=2, five consecutive error frames -> err_count 1,2,3,3,3.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Frame-level parity checker: accumulates XOR parity over FRAME_LEN words and reports even/odd mismatches.
// Optional per-word parity checking is enabled by defining PARITY_FRAME_WORD_CHECK_EN.
module parity_frame_checker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             frame_abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_parity,
`ifdef PARITY_FRAME_WORD_CHECK_EN
  input  logic             in_word_parity,
  output logic             out_word_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic             out_parity,
  output logic [CNT_W-1:0] err_count
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          mode_q;
  logic          in_fire;
  logic          take;
  logic          out_fire;
  logic          last;
  logic          abort_now;
  logic          mode_eff;
  logic          word_par;
  logic          frame_par;
  logic          result_bad;

  assign in_ready  = (state != REPORT);
  assign out_valid = (state == REPORT);
  assign in_fire   = in_valid & in_ready;
  assign abort_now = frame_abort & (state != REPORT);
  assign take      = in_fire & ~frame_abort;
  assign out_fire  = out_valid & out_ready;
  assign last      = (cnt == LAST_IDX);
  // The first word of a frame is judged with the live mode; later words use the latched one.
  assign mode_eff  = (state == IDLE) ? odd_mode : mode_q;
  assign word_par  = ^in_data;
  assign frame_par = acc ^ word_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACCUM: begin
        if (frame_abort) begin
          next_state = IDLE;
        end else if (in_fire) begin
          next_state = last ? REPORT : ACCUM;
        end
      end
      REPORT: begin
        if (out_fire) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // acc and cnt are cleared as the last word lands, so they are already zero in REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
    end else if (abort_now) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (take) begin
      if (state == IDLE) begin
        mode_q <= odd_mode;
      end
      if (last) begin
        acc        <= 1'b0;
        cnt        <= '0;
        out_parity <= frame_par;
        out_err    <= frame_par ^ in_parity ^ mode_eff;
      end else begin
        acc <= frame_par;
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef PARITY_FRAME_WORD_CHECK_EN
  logic word_bad;
  logic word_sticky;

  assign word_bad = word_par ^ in_word_parity ^ mode_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_sticky  <= 1'b0;
      out_word_err <= 1'b0;
    end else if (abort_now) begin
      word_sticky  <= 1'b0;
      out_word_err <= 1'b0;
    end else if (take) begin
      if (last) begin
        out_word_err <= word_sticky | word_bad;
        word_sticky  <= 1'b0;
      end else begin
        word_sticky <= word_sticky | word_bad;
      end
    end else if (out_fire) begin
      out_word_err <= 1'b0;
    end
  end

  assign result_bad = out_err | out_word_err;
`else
  assign result_bad = out_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_fire && result_bad && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
